// File: rtl/st_if_pkg.sv
// Shared types and constants for the self-timed Send/Ack receive boundary.
package st_if_pkg;

  // Receiver handshake states.
  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    RELEASE = 2'd2,
    FULL    = 2'd3
  } st_state_t;

  localparam int SYNC_STAGES_DEF = 2;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through STAGES flops; the last one is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/st_sync_rx.sv
// Clocked receiver for a 4-phase bundled-data Send/Ack channel. Send_in is
// synchronized, Data_in is captured directly (its bundling margin is covered
// by the synchronizer latency), and tokens are buffered in a small FIFO.
//
// Read side handshake: rd_valid high means rd_data holds the oldest token;
// a word is consumed on every rising CLK edge where rd_valid && rd_ready.
// rd_data and rd_valid never change while rd_valid=1 and rd_ready=0.
module st_sync_rx
  import st_if_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                      CLK,
  input  logic                      MR_n,
  input  logic                      Send_in,
  input  logic [DATA_W-1:0]         Data_in,
  output logic                      Ack_out,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output st_state_t                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic              send_s;
  st_state_t         state_q;
  st_state_t         state_d;
  logic              armed_q;
  logic              ack_q;
  logic              ack_d;
  logic              push;
  logic              pop;
  logic              space;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] mem [DEPTH];

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_send_sync (
    .clk   (CLK),
    .rst_n (MR_n),
    .d     (Send_in),
    .q     (send_s)
  );

  // A token is taken the moment the synchronized request is seen in IDLE;
  // IDLE is only ever entered with space, so push never hits a full FIFO.
  assign push     = (state_q == IDLE) && send_s;
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid && rd_ready;

  // Occupancy after this edge; push and pop together cancel out.
  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + 1'b1;
    end else if (!push && pop) begin
      count_next = count_q - 1'b1;
    end
  end

  assign space = (count_next < DEPTH_C);

  // armed_q marks the first edge after reset release so ARM lasts one full cycle.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Handshake state register and registered Ack_out.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state_q <= ARM;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic; Ack_out is high exactly while the receiver sits in IDLE.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      ARM: begin
        if (armed_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (send_s) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!send_s) begin
          state_d = space ? IDLE : FULL;
        end
      end
      FULL: begin
        if (space) begin
          state_d = IDLE;
        end
      end
      default: state_d = ARM;
    endcase
    ack_d = (state_d == IDLE);
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_next;
    end
  end

  // Token storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q] <= Data_in;
    end
  end

  assign rd_data   = rd_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign Ack_out   = ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_st_sync_rx.sv
// Directed testbench for st_sync_rx: handshake latency, fill/full, concurrent
// drain, pointer wrap with stalls, and reset behaviour.
module tb_st_sync_rx;
  import st_if_pkg::*;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic              CLK = 1'b0;
  logic              MR_n;
  logic              Send_in;
  logic [DATA_W-1:0] Data_in;
  logic              Ack_out;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        count;
  st_state_t         dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int rd_mode     = 0;   // 0: hold rd_ready low, 1: high, 2: random
  int max_count   = 0;
  logic [DATA_W-1:0] exp_q[$];

  st_sync_rx #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .CLK       (CLK),
    .MR_n      (MR_n),
    .Send_in   (Send_in),
    .Data_in   (Data_in),
    .Ack_out   (Ack_out),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // Clock: rising edge is active; the bench drives and samples on falling edges.
  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard any pop across the edge, check head stability on
  // a stall, track peak occupancy, then drive the next rd_ready.
  task automatic cycle();
    logic              pop_pend;
    logic              stall;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] exp_word;
    pop_pend = rd_valid && rd_ready;
    stall    = rd_valid && !rd_ready;
    head     = rd_data;
    @(negedge CLK);
    if (pop_pend) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL pop_extra observed=%h expected=none", head);
      end
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("pop_data", head, exp_word);
      end
    end
    if (stall) begin
      check("hold_valid", {31'd0, rd_valid}, 32'd1);
      check("hold_data", rd_data, head);
    end
    if (int'(count) > max_count) max_count = int'(count);
    case (rd_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_ack(input logic level, input string tag);
    int n;
    n = 0;
    while (Ack_out !== level && n < 40) begin
      cycle();
      n++;
    end
    check(tag, {31'd0, Ack_out}, {31'd0, level});
  endtask

  task automatic send_token(input logic [DATA_W-1:0] data, input logic expect_rise,
                            input string tag);
    Send_in = 1'b1;
    Data_in = data;
    exp_q.push_back(data);
    wait_ack(1'b0, {tag, "_fall"});
    Send_in = 1'b0;
    Data_in = ~data;
    if (expect_rise) wait_ack(1'b1, {tag, "_rise"});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rd_mode  = 1;
    rd_ready = 1'b1;
    while (count != 3'd0 && n < 40) begin
      cycle();
      n++;
    end
    rd_mode  = 0;
    rd_ready = 1'b0;
    check({tag, "_count"}, {29'd0, count}, 32'd0);
    check({tag, "_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    MR_n     = 1'b0;
    Send_in  = 1'b0;
    Data_in  = '0;
    rd_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge CLK);
    check("rst_ack",   {31'd0, Ack_out},  32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_count", {29'd0, count},    32'd0);
    check("rst_data",  rd_data,           32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ARM});
    MR_n = 1'b1;
    cycle();
    check("arm_ack", {31'd0, Ack_out}, 32'd0);
    cycle();
    check("idle_ack",   {31'd0, Ack_out},   32'd1);
    check("idle_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Single token with exact edge latency.
    Send_in = 1'b1;
    Data_in = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    cycle();
    check("t1_ack_e1", {31'd0, Ack_out}, 32'd1);
    cycle();
    check("t1_ack_e2", {31'd0, Ack_out}, 32'd1);
    cycle();
    check("t1_ack_e3",  {31'd0, Ack_out},   32'd0);
    check("t1_valid",   {31'd0, rd_valid},  32'd1);
    check("t1_data",    rd_data,            32'hA5A5_0001);
    check("t1_count",   {29'd0, count},     32'd1);
    check("t1_release", {30'd0, dbg_state}, {30'd0, RELEASE});
    Send_in = 1'b0;
    Data_in = 32'h0;
    cycle();
    cycle();
    check("t1_rise_e2", {31'd0, Ack_out}, 32'd0);
    cycle();
    check("t1_rise_e3", {31'd0, Ack_out}, 32'd1);
    rd_ready = 1'b1;
    cycle();
    check("t1_pop_count", {29'd0, count},    32'd0);
    check("t1_pop_valid", {31'd0, rd_valid}, 32'd0);

    // Fill to DEPTH, confirm FULL holds Ack low, one pop re-arms.
    send_token(32'd1, 1'b1, "fill1");
    send_token(32'd2, 1'b1, "fill2");
    send_token(32'd3, 1'b1, "fill3");
    send_token(32'd4, 1'b0, "fill4");
    repeat (6) cycle();
    check("full_ack",   {31'd0, Ack_out},   32'd0);
    check("full_state", {30'd0, dbg_state}, {30'd0, FULL});
    check("full_count", {29'd0, count},     32'd4);
    rd_ready = 1'b1;
    cycle();
    check("full_pop_ack",   {31'd0, Ack_out},   32'd1);
    check("full_pop_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("full_pop_count", {29'd0, count},     32'd3);
    drain("fill_drain");

    // Concurrent drain: consumer always ready.
    rd_mode   = 1;
    rd_ready  = 1'b1;
    max_count = 0;
    for (int i = 0; i < 8; i++) send_token(32'h10 + i, 1'b1, "conc");
    drain("conc_drain");
    check("conc_max", {31'd0, max_count <= 1}, 32'd1);

    // Pointer wrap with random consumer stalls.
    rd_mode = 2;
    for (int i = 0; i < 10; i++) send_token(32'h100 + i, 1'b1, "wrap");
    drain("wrap_drain");

    // Reset while in RELEASE with two tokens buffered.
    send_token(32'h51, 1'b1, "mid1");
    Send_in = 1'b1;
    Data_in = 32'h52;
    wait_ack(1'b0, "mid2_fall");
    check("mid_state", {30'd0, dbg_state}, {30'd0, RELEASE});
    check("mid_count", {29'd0, count},     32'd2);
    #2;
    MR_n    = 1'b0;
    Send_in = 1'b0;
    #1;
    check("mid_rst_ack",   {31'd0, Ack_out},  32'd0);
    check("mid_rst_count", {29'd0, count},    32'd0);
    check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    MR_n = 1'b1;
    cycle();
    check("mid_rel_e1", {31'd0, Ack_out}, 32'd0);
    cycle();
    check("mid_rel_e2", {31'd0, Ack_out}, 32'd1);

    // Send_in already high when reset releases: exactly one token.
    MR_n    = 1'b0;
    Send_in = 1'b1;
    Data_in = 32'hD6D6_0006;
    cycle();
    MR_n = 1'b1;
    exp_q.push_back(32'hD6D6_0006);
    cycle();
    check("hi_e1_ack", {31'd0, Ack_out}, 32'd0);
    cycle();
    check("hi_e2_ack", {31'd0, Ack_out}, 32'd1);
    cycle();
    check("hi_e3_ack",   {31'd0, Ack_out}, 32'd0);
    check("hi_e3_count", {29'd0, count},   32'd1);
    repeat (6) cycle();
    check("hi_hold_ack",   {31'd0, Ack_out}, 32'd0);
    check("hi_hold_count", {29'd0, count},   32'd1);
    Send_in = 1'b0;
    wait_ack(1'b1, "hi_rise");
    check("hi_rise_count", {29'd0, count}, 32'd1);
    drain("hi_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
